// File: rtl/crtc_pkg.sv
// Shared slot timing for the CRTC/VRAM sequencer: phase constants, CPU slot FSM
// states and a slot-start helper.
package crtc_pkg;

  localparam logic [3:0] PH_VID0   = 4'd0;
  localparam logic [3:0] PH_VID1   = 4'd4;
  localparam logic [3:0] PH_CPUA   = 4'd8;
  localparam logic [3:0] PH_CPUB   = 4'd12;
  localparam logic [3:0] RD_LAT    = 4'd2;
  localparam logic [3:0] PH_VOUT   = 4'd7;
  localparam logic [3:0] PH_NCLKEN = 4'd7;
  localparam logic [3:0] PH_CLKEN  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } cpu_state_t;

  function automatic logic is_cpu_slot(input logic [3:0] ph);
    return (ph == PH_CPUA) || (ph == PH_CPUB);
  endfunction

endpackage

// File: rtl/cpc_vaddr_map.sv
// CRTC MA/RA to 16-bit VRAM byte address: {MA[13:12], RA[2:0], MA[9:0], byte}.
module cpc_vaddr_map (
  input  logic [13:0] i_ma,
  input  logic [4:0]  i_ra,
  input  logic        i_byte_sel,
  output logic [15:0] o_addr
);

  // MA[11:10] and RA[4:3] do not take part in the mapping.
  logic w_unused_bits;
  assign w_unused_bits = ^{i_ma[11:10], i_ra[4:3]};

  assign o_addr = {i_ma[13:12], i_ra[2:0], i_ma[9:0], i_byte_sel};

endmodule

// File: rtl/crtc_vram_sequencer.sv
// 16-phase VRAM time-slot sequencer: two video byte fetches per character
// followed by two CPU access slots, plus CRTC clock enables.
module crtc_vram_sequencer
  import crtc_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset,
  output logic        o_crtc_clken,
  output logic        o_crtc_nclken,
  input  logic [13:0] i_ma,
  input  logic [4:0]  i_ra,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [15:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_wdata,
  output logic        o_cpu_ack,
  output logic [7:0]  o_cpu_rdata,
  output logic        o_cpu_wait,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic [7:0]  o_mem_wdata,
  input  logic [7:0]  i_mem_rdata,
  output logic [15:0] o_vid_data,
  output logic        o_vid_valid,
  output logic [1:0]  o_dbg_state,
  output logic [3:0]  o_dbg_phase
);

  // Handshake: the CPU holds i_cpu_req (with addr/we/wdata) until o_cpu_ack;
  // o_cpu_wait = i_cpu_req & ~o_cpu_ack. A request low at a slot start is dropped.

  logic [3:0]  r_phase;
  cpu_state_t  r_state;
  logic [13:0] r_ma;
  logic [4:0]  r_ra;
  logic [7:0]  r_byte0;
  logic [7:0]  r_byte1;
  logic        r_cpu_we;
  logic        r_crtc_clken;
  logic        r_crtc_nclken;
  logic        r_cpu_ack;
  logic [7:0]  r_cpu_rdata;
  logic [15:0] r_mem_addr;
  logic        r_mem_rd;
  logic        r_mem_wr;
  logic [7:0]  r_mem_wdata;
  logic [15:0] r_vid_data;
  logic        r_vid_valid;

  logic [13:0] w_map_ma;
  logic [4:0]  w_map_ra;
  logic        w_byte_sel;
  logic [15:0] w_vaddr;
  logic        w_cpu_start;

  // Byte 0 uses the live MA/RA (the sampling edge); byte 1 uses the held copy.
  assign w_map_ma   = (r_phase == PH_VID0) ? i_ma : r_ma;
  assign w_map_ra   = (r_phase == PH_VID0) ? i_ra : r_ra;
  assign w_byte_sel = (r_phase == PH_VID1);
  assign w_cpu_start = is_cpu_slot(r_phase) && i_cpu_req && (r_state == ST_IDLE);

  cpc_vaddr_map u_vaddr_map (
    .i_ma       (w_map_ma),
    .i_ra       (w_map_ra),
    .i_byte_sel (w_byte_sel),
    .o_addr     (w_vaddr)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_phase       <= 4'd0;
      r_state       <= ST_IDLE;
      r_ma          <= 14'd0;
      r_ra          <= 5'd0;
      r_byte0       <= 8'd0;
      r_byte1       <= 8'd0;
      r_cpu_we      <= 1'b0;
      r_crtc_clken  <= 1'b0;
      r_crtc_nclken <= 1'b0;
      r_cpu_ack     <= 1'b0;
      r_cpu_rdata   <= 8'd0;
      r_mem_addr    <= 16'd0;
      r_mem_rd      <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_mem_wdata   <= 8'd0;
      r_vid_data    <= 16'd0;
      r_vid_valid   <= 1'b0;
    end else begin
      r_phase       <= r_phase + 4'd1;
      r_crtc_clken  <= (r_phase == PH_CLKEN);
      r_crtc_nclken <= (r_phase == PH_NCLKEN);
      r_mem_rd      <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_vid_valid   <= 1'b0;
      r_cpu_ack     <= 1'b0;

      if ((r_phase == PH_VID0) || (r_phase == PH_VID1)) begin
        r_mem_rd   <= 1'b1;
        r_mem_addr <= w_vaddr;
      end
      if (r_phase == PH_VID0) begin
        r_ma <= i_ma;
        r_ra <= i_ra;
      end
      if (r_phase == PH_VID0 + RD_LAT) r_byte0 <= i_mem_rdata;
      if (r_phase == PH_VID1 + RD_LAT) r_byte1 <= i_mem_rdata;
      if (r_phase == PH_VOUT) begin
        r_vid_data  <= {r_byte1, r_byte0};
        r_vid_valid <= 1'b1;
      end

      // CPU slots start on a 4-phase boundary, so phase[1:0] is the slot offset.
      case (r_state)
        ST_IDLE: begin
          if (w_cpu_start) begin
            r_state    <= ST_ACCESS;
            r_cpu_we   <= i_cpu_we;
            r_mem_addr <= i_cpu_addr;
            r_mem_rd   <= ~i_cpu_we;
            r_mem_wr   <= i_cpu_we;
            if (i_cpu_we) r_mem_wdata <= i_cpu_wdata;
          end
        end
        ST_ACCESS: begin
          if (r_phase[1:0] == RD_LAT[1:0]) begin
            r_state   <= ST_ACK;
            r_cpu_ack <= 1'b1;
            if (!r_cpu_we) r_cpu_rdata <= i_mem_rdata;
          end
        end
        ST_ACK:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_crtc_clken  = r_crtc_clken;
  assign o_crtc_nclken = r_crtc_nclken;
  assign o_cpu_ack     = r_cpu_ack;
  assign o_cpu_rdata   = r_cpu_rdata;
  assign o_cpu_wait    = i_cpu_req & ~r_cpu_ack;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_rd      = r_mem_rd;
  assign o_mem_wr      = r_mem_wr;
  assign o_mem_wdata   = r_mem_wdata;
  assign o_vid_data    = r_vid_data;
  assign o_vid_valid   = r_vid_valid;
  assign o_dbg_state   = r_state;
  assign o_dbg_phase   = r_phase;

endmodule
